rr_grant_sched: RTL and testbench
=================================

RR_GRANT_SCHED -- requirements
Module: rr_grant_sched

Interface
REQ-001 Parameter MAX_HOLD, default 4, meaning max consecutive GRANT cycles per holder while others wait; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high.
REQ-004 en  input  1  scheduler enable; low forces grant to zero.
REQ-005 req  input  8  request per requester, level-held while service is wanted.
REQ-006 grant  output  8  registered one-hot grant, all-zero when none.
REQ-007 gnt_idx  output  3  index of current/last granted requester.
REQ-008 gnt_valid  output  1  high exactly when grant is non-zero.

Function
REQ-009 FSM states SHALL be IDLE, GRANT and GAP, with a 3-bit last_idx and a hold counter.
REQ-010 Selection SHALL be round-robin: search req starting at last_idx+1 modulo 8, wrapping 7->0; first set bit wins.
REQ-011 IDLE, en=1, req!=0 at edge N SHALL give GRANT with grant=onehot(winner), gnt_idx=winner, visible after edge N (1-cycle latency).
REQ-012 grant SHALL equal the decode of gnt_idx whenever gnt_valid=1 and SHALL be 8'h00 otherwise.
REQ-013 On entering GRANT, hold counter SHALL load 1 and last_idx SHALL load the winner.
REQ-014 In GRANT, counter SHALL increment each cycle the holder's req stays high, saturating at MAX_HOLD.
REQ-015 In GRANT, holder req low at an edge SHALL give GAP (grant zero) next cycle.
REQ-016 In GRANT, counter==MAX_HOLD and any other req bit high SHALL give GAP next cycle (forced rotation).
REQ-017 In GRANT, counter==MAX_HOLD with no other requester SHALL keep the grant (no needless gap).
REQ-018 GAP SHALL last exactly one cycle with grant=0; then GRANT to next round-robin winner if req!=0 and en=1, else IDLE.
REQ-019 Holder dropping req while others request in same cycle SHALL still produce exactly one GAP cycle.
REQ-020 en low at any edge SHALL give IDLE next cycle, grant=0, last_idx retained; counter cleared.
REQ-021 In IDLE with req=0 or en=0, outputs SHALL hold grant=0, gnt_valid=0, gnt_idx=last_idx.
REQ-022 No two grant bits SHALL ever be high in the same cycle.

Reset
REQ-023 rst high at an edge SHALL force IDLE, grant=8'h00, gnt_valid=0, counter=0, last_idx=3'd7, regardless of state.
REQ-024 After reset, first arbitration SHALL start its search at index 0.
REQ-025 rst asserted mid-GRANT SHALL drop grant on the next cycle with no GAP state.

Structure
REQ-026 Shared package rr_sched_pkg SHALL hold N_REQ=8, IDX_W=3, and the state encoding IDLE/GRANT/GAP.
REQ-027 One sub-module onehot_dec3 (3-bit index plus enable in, 8-bit one-hot out, combinational) SHALL generate grant from gnt_idx and gnt_valid.
REQ-028 Winner search SHALL be combinational within rr_grant_sched; all outputs SHALL be registered or decoded from registers only.

Verification
REQ-029 rst, then req=8'h01, en=1 -> grant=8'h01, gnt_idx=0 one cycle later; held while req[0]=1.
REQ-030 req=8'hFF held, MAX_HOLD=4 -> grants 0,1,2,...,7,0 each 4 cycles, one zero GAP cycle between.
REQ-031 Holder 5 only requester for 10 cycles -> grant=8'h20 continuously, no gaps.
REQ-032 Holder 3 drops req while req[6]=1 same cycle -> 1 GAP cycle, then grant=8'h40.
REQ-033 en=0 mid-grant of idx 2, then en=1 with req=8'h05 -> grant 0 next cycle, then grant=8'h01 (search from 3 wraps to 0).
REQ-034 rst pulse mid-GRANT of idx 4 with req=8'h10 -> grant 0 next cycle, then grant=8'h10 after rst release.

Source files
------------

// File: rtl/rr_sched_pkg.sv
// rtl/rr_sched_pkg.sv - shared sizes and state encoding for the round-robin grant scheduler
package rr_sched_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;
endpackage

// File: rtl/onehot_dec3.sv
// rtl/onehot_dec3.sv - 3-bit index to 8-bit one-hot decoder with enable
module onehot_dec3 (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] onehot
);
    assign onehot = en ? (8'b0000_0001 << idx) : 8'h00;
endmodule

// File: rtl/rr_grant_sched.sv
// rtl/rr_grant_sched.sv - 8-way round-robin grant scheduler with bounded hold time
module rr_grant_sched #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);
    import rr_sched_pkg::*;

    localparam logic [3:0] MAX_CNT = 4'(MAX_HOLD);

    state_t           state;
    logic [IDX_W-1:0] last_idx;
    logic [3:0]       hold_cnt;

    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [IDX_W-1:0] cand;
    logic [N_REQ-1:0] holder_mask;
    logic             holder_req;
    logic             others_req;

    // Search begins just past the last holder; i == N_REQ revisits the holder itself last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_idx;
        cand      = last_idx;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = last_idx + IDX_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign holder_mask = N_REQ'(1) << last_idx;
    assign holder_req  = req[last_idx];
    assign others_req  = |(req & ~holder_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_idx <= 3'd7;
            hold_cnt <= 4'd0;
        end else if (!en) begin
            state    <= IDLE;
            hold_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (win_found) begin
                        state    <= GRANT;
                        last_idx <= win_idx;
                        hold_cnt <= 4'd1;
                    end else begin
                        state    <= IDLE;
                        hold_cnt <= 4'd0;
                    end
                end
                GRANT: begin
                    // A lone requester keeps the grant past MAX_HOLD; rotation only when someone waits.
                    if (!holder_req || (hold_cnt == MAX_CNT && others_req)) begin
                        state    <= GAP;
                        hold_cnt <= 4'd0;
                    end else if (hold_cnt != MAX_CNT) begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign gnt_valid = (state == GRANT);
    assign gnt_idx   = last_idx;

    onehot_dec3 u_dec (
        .idx    (gnt_idx),
        .en     (gnt_valid),
        .onehot (grant)
    );
endmodule

// File: tb/tb_rr_grant_sched.sv
// tb/tb_rr_grant_sched.sv - randomized and directed check of rr_grant_sched against a behavioural model
module tb_rr_grant_sched;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Model: who holds the grant (or -1), whether a gap is pending, how long held.
    int m_holder = -1;
    int m_last   = 7;
    int m_held   = 0;
    bit m_in_gap = 1'b0;

    rr_grant_sched #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .grant     (grant),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [7:0] r, input int from);
        for (int k = 1; k <= 8; k++) begin
            if (r[(from + k) % 8]) return (from + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        int others;
        if (rst) begin
            m_holder = -1; m_in_gap = 0; m_held = 0; m_last = 7;
        end else if (!en) begin
            m_holder = -1; m_in_gap = 0; m_held = 0;
        end else if (m_holder >= 0) begin
            others = (req & ~(8'd1 << m_holder)) != 0;
            if (!req[m_holder] || (m_held >= MAX_HOLD && others != 0)) begin
                m_holder = -1; m_in_gap = 1; m_held = 0;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end else begin
            m_in_gap = 0;
            w = rr_pick(req, m_last);
            if (w >= 0) begin
                m_holder = w; m_last = w; m_held = 1;
            end
        end
    endtask

    task automatic step();
        logic [7:0] exp_grant;
        @(posedge clk);
        model_edge();
        #1;
        exp_grant = (m_holder >= 0) ? (8'd1 << m_holder) : 8'h00;
        chk("grant", 32'(grant), 32'(exp_grant));
        chk("gnt_idx", 32'(gnt_idx), 32'(m_last));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_holder >= 0));
        chk("onehot", 32'($countones(grant) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'h00;
        run(2);
        chk("reset_grant", 32'(grant), 32'h00);
        chk("reset_idx", 32'(gnt_idx), 32'd7);
        chk("reset_valid", 32'(gnt_valid), 32'd0);

        rst = 1'b0; en = 1'b1; req = 8'h01;
        step();
        chk("first_grant", 32'(grant), 32'h01);
        run(5);

        req = 8'hFF;
        run(45);

        req = 8'h20;
        run(14);
        chk("lone_holder", 32'(grant), 32'h20);

        req = 8'h08;
        run(4);
        req = 8'h40;
        step();
        chk("drop_gap", 32'(grant), 32'h00);
        step();
        chk("after_gap", 32'(grant), 32'h40);

        req = 8'h04;
        run(4);
        chk("hold_idx2", 32'(grant), 32'h04);
        en = 1'b0;
        step();
        chk("en_low", 32'(grant), 32'h00);
        en = 1'b1; req = 8'h05;
        step();
        chk("wrap_pick", 32'(grant), 32'h01);

        req = 8'h10;
        run(4);
        chk("hold_idx4", 32'(grant), 32'h10);
        rst = 1'b1;
        step();
        chk("rst_mid", 32'(grant), 32'h00);
        rst = 1'b0;
        step();
        chk("post_rst", 32'(grant), 32'h10);

        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            end
            en  = ($urandom_range(0, 29) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
